// File: rtl/pipe_stage_elastic.sv
// Elastic valid/ready pipeline stage with flush-to-NOP and a saturating backpressure counter.
// Define PIPE_STAGE_SKID_EN to add a skid entry and register o_ready.
module pipe_stage_elastic #(
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] NOP_DATA = DATA_W'(32'h0000_0013),
    parameter int                CNT_W    = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_flush,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic [1:0]        o_occupancy,
    output logic [CNT_W-1:0]  o_stall_cnt
);

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t             state_p0;
    logic [DATA_W-1:0]  data_p0;
    logic               vld_p0;
    logic [CNT_W-1:0]   stall_cnt_p0;
    logic               accept;
    logic               issue;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                                 input logic              en);
        if (en && (cnt != {CNT_W{1'b1}}))
            return cnt + CNT_W'(1);
        return cnt;
    endfunction

    assign vld_p0      = (state_p0 != EMPTY);
    assign accept      = i_valid && o_ready;
    assign issue       = vld_p0 && i_ready;
    assign o_valid     = vld_p0;
    assign o_data      = data_p0;
    assign o_occupancy = state_p0;
    assign o_stall_cnt = stall_cnt_p0;

    // Stall counter survives flush; only reset clears it.
    always_ff @(posedge i_clk) begin
        if (i_rst)
            stall_cnt_p0 <= '0;
        else
            stall_cnt_p0 <= sat_inc(stall_cnt_p0, vld_p0 && !i_ready);
    end

`ifdef PIPE_STAGE_SKID_EN
    logic               ready_p0;
    logic [DATA_W-1:0]  skid_p0;

    assign o_ready = ready_p0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_p0 <= EMPTY;
            data_p0  <= NOP_DATA;
            ready_p0 <= 1'b1;
        end else if (i_flush) begin
            state_p0 <= EMPTY;
            data_p0  <= NOP_DATA;
            ready_p0 <= 1'b1;
        end else begin
            case (state_p0)
                EMPTY: begin
                    if (accept) begin
                        state_p0 <= BUSY;
                        data_p0  <= i_data;
                    end
                end
                BUSY: begin
                    if (accept && issue) begin
                        data_p0 <= i_data;
                    end else if (accept) begin
                        state_p0 <= FULL;
                        ready_p0 <= 1'b0;
                    end else if (issue) begin
                        state_p0 <= EMPTY;
                        data_p0  <= NOP_DATA;
                    end
                end
                FULL: begin
                    if (issue) begin
                        state_p0 <= BUSY;
                        data_p0  <= skid_p0;
                        ready_p0 <= 1'b1;
                    end
                end
                default: begin
                    state_p0 <= EMPTY;
                    data_p0  <= NOP_DATA;
                    ready_p0 <= 1'b1;
                end
            endcase
        end
    end

    // Skid contents are only meaningful in FULL, so no reset is needed here.
    always_ff @(posedge i_clk) begin
        if ((state_p0 == BUSY) && accept && !issue)
            skid_p0 <= i_data;
    end
`else
    assign o_ready = !vld_p0 || i_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_p0 <= EMPTY;
            data_p0  <= NOP_DATA;
        end else if (i_flush) begin
            state_p0 <= EMPTY;
            data_p0  <= NOP_DATA;
        end else begin
            case (state_p0)
                EMPTY: begin
                    if (accept) begin
                        state_p0 <= BUSY;
                        data_p0  <= i_data;
                    end
                end
                BUSY: begin
                    if (issue) begin
                        if (accept) begin
                            data_p0 <= i_data;
                        end else begin
                            state_p0 <= EMPTY;
                            data_p0  <= NOP_DATA;
                        end
                    end
                end
                default: begin
                    state_p0 <= EMPTY;
                    data_p0  <= NOP_DATA;
                end
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed self-checking bench for pipe_stage_elastic (CNT_W = 2 to reach saturation quickly).
// Follows PIPE_STAGE_SKID_EN to pick the skid or no-skid expectations.
module tb_pipe_stage_elastic;

    localparam int          DATA_W = 32;
    localparam int          CNT_W  = 2;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              out_ready_dut;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occ;
    logic [CNT_W-1:0]  stall_cnt;

    int checks;
    int failures;

    pipe_stage_elastic #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_flush     (flush),
        .i_valid     (in_valid),
        .o_ready     (out_ready_dut),
        .i_data      (in_data),
        .o_valid     (out_valid),
        .i_ready     (in_ready),
        .o_data      (out_data),
        .o_occupancy (occ),
        .o_stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_ready = 1'b0; in_data = '0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== NOP) begin failures++; $display("FAIL reset_data: got %h expected %h", out_data, NOP); end
        checks++; if (out_ready_dut !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", out_ready_dut); end
        checks++; if (occ !== 2'd0) begin failures++; $display("FAIL reset_occ: got %0d expected 0", occ); end
        checks++; if (stall_cnt !== 2'd0) begin failures++; $display("FAIL reset_stall: got %0d expected 0", stall_cnt); end
    endtask

    task automatic test_stream();
        do_reset();
        in_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            in_valid = 1'b1; in_data = k;
            step();
            checks++; if (out_valid !== 1'b1 || out_data !== k) begin
                failures++; $display("FAIL stream_%0d: got v=%b d=%h expected v=1 d=%h", k, out_valid, out_data, k);
            end
        end
        in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0 || out_data !== NOP) begin
            failures++; $display("FAIL stream_drain: got v=%b d=%h expected v=0 d=%h", out_valid, out_data, NOP);
        end
        checks++; if (stall_cnt !== 2'd0) begin failures++; $display("FAIL stream_stall: got %0d expected 0", stall_cnt); end
    endtask

    task automatic test_backpressure();
        do_reset();
        in_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
        step();
        checks++; if (out_data !== 32'hA || occ !== 2'd1) begin
            failures++; $display("FAIL bp_first: got d=%h occ=%0d expected d=a occ=1", out_data, occ);
        end
        in_data = 32'hB;
`ifdef PIPE_STAGE_SKID_EN
        step();
        in_valid = 1'b0;
        #1;
        checks++; if (occ !== 2'd2 || out_ready_dut !== 1'b0) begin
            failures++; $display("FAIL bp_full: got occ=%0d rdy=%b expected occ=2 rdy=0", occ, out_ready_dut);
        end
        step();
        in_ready = 1'b1;
        #1;
        checks++; if (out_data !== 32'hA) begin failures++; $display("FAIL bp_order_a: got %h expected a", out_data); end
        step();
        checks++; if (out_valid !== 1'b1 || out_data !== 32'hB || out_ready_dut !== 1'b1 || occ !== 2'd1) begin
            failures++; $display("FAIL bp_order_b: got v=%b d=%h rdy=%b occ=%0d expected v=1 d=b rdy=1 occ=1",
                                 out_valid, out_data, out_ready_dut, occ);
        end
        step();
        checks++; if (out_valid !== 1'b0 || out_data !== NOP) begin
            failures++; $display("FAIL bp_drain: got v=%b d=%h expected v=0 d=%h", out_valid, out_data, NOP);
        end
`else
        #1;
        checks++; if (out_ready_dut !== 1'b0) begin failures++; $display("FAIL bp_rdy_low: got %b expected 0", out_ready_dut); end
        step();
        in_valid = 1'b0;
        checks++; if (occ !== 2'd1 || out_data !== 32'hA) begin
            failures++; $display("FAIL bp_hold: got occ=%0d d=%h expected occ=1 d=a", occ, out_data);
        end
        in_ready = 1'b1;
        #1;
        checks++; if (out_ready_dut !== 1'b1) begin failures++; $display("FAIL bp_rdy_follow_hi: got %b expected 1", out_ready_dut); end
        in_ready = 1'b0;
        #1;
        checks++; if (out_ready_dut !== 1'b0) begin failures++; $display("FAIL bp_rdy_follow_lo: got %b expected 0", out_ready_dut); end
        step();
        in_ready = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0 || out_data !== NOP || occ !== 2'd0) begin
            failures++; $display("FAIL bp_drain: got v=%b d=%h occ=%0d expected v=0 d=%h occ=0", out_valid, out_data, occ, NOP);
        end
`endif
        checks++; if (stall_cnt !== 2'd2) begin failures++; $display("FAIL bp_stall: got %0d expected 2", stall_cnt); end
    endtask

    task automatic test_flush();
        do_reset();
        in_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
        step();
        in_data = 32'hB;
        step();
        flush = 1'b1; in_data = 32'hC;
        step();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || out_data !== NOP || occ !== 2'd0 || out_ready_dut !== 1'b1) begin
            failures++; $display("FAIL flush_state: got v=%b d=%h occ=%0d rdy=%b expected v=0 d=%h occ=0 rdy=1",
                                 out_valid, out_data, occ, out_ready_dut, NOP);
        end
        checks++; if (stall_cnt !== 2'd2) begin failures++; $display("FAIL flush_stall_kept: got %0d expected 2", stall_cnt); end
        in_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (out_valid !== 1'b0 || out_data === 32'hC) begin
                failures++; $display("FAIL flush_no_c_%0d: got v=%b d=%h expected v=0 d=%h", k, out_valid, out_data, NOP);
            end
        end
    endtask

    task automatic test_stall_sat();
        logic [CNT_W-1:0] exp_cnt;
        do_reset();
        in_ready = 1'b0; in_valid = 1'b1; in_data = 32'h5;
        step();
        in_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            exp_cnt = (k > 3) ? 2'd3 : CNT_W'(k);
            checks++; if (stall_cnt !== exp_cnt) begin
                failures++; $display("FAIL sat_cycle_%0d: got %0d expected %0d", k, stall_cnt, exp_cnt);
            end
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++; if (stall_cnt !== 2'd3 || out_valid !== 1'b0) begin
            failures++; $display("FAIL sat_after_flush: got cnt=%0d v=%b expected cnt=3 v=0", stall_cnt, out_valid);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (stall_cnt !== 2'd0) begin failures++; $display("FAIL sat_after_rst: got %0d expected 0", stall_cnt); end
    endtask

    task automatic test_rst_flush();
        do_reset();
        in_ready = 1'b0; in_valid = 1'b1; in_data = 32'h7;
        step();
        checks++; if (occ !== 2'd1) begin failures++; $display("FAIL rf_busy: got occ=%0d expected 1", occ); end
        rst = 1'b1; flush = 1'b1; in_data = 32'hD;
        step();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || out_data !== NOP || out_ready_dut !== 1'b1 || occ !== 2'd0 || stall_cnt !== 2'd0) begin
            failures++; $display("FAIL rf_reset_vals: got v=%b d=%h rdy=%b occ=%0d cnt=%0d expected v=0 d=%h rdy=1 occ=0 cnt=0",
                                 out_valid, out_data, out_ready_dut, occ, stall_cnt, NOP);
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_ready = 1'b0; in_data = '0;
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_stall_sat();
        test_rst_flush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
